// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel state
// encoding and prescaler sizing.
package timer_pkg;

    typedef logic [1:0] timer_state_t;

    localparam timer_state_t StIdle   = 2'd0;
    localparam timer_state_t StRun    = 2'd1;
    localparam timer_state_t StPaused = 2'd2;

    // Phase counter width; a single-cycle prescaler still needs one bit.
    function automatic int unsigned prescaler_width(input int unsigned ticks);
        int unsigned w;
        w = $clog2(ticks);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/multi_countdown_timer_if.sv
// Control/status bundle between the control FSM and the timer block.
interface multi_countdown_timer_if #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned CHANNELS = 2
);
    logic [CHANNELS-1:0]       beginCount;
    logic [CHANNELS-1:0]       pause;
    logic [CHANNELS-1:0]       reloadMode;
    logic [CHANNELS*WIDTH-1:0] counterSeconds;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS-1:0]       done;

    modport master (
        output beginCount, pause, reloadMode, counterSeconds,
        input  count, busy, done
    );

    modport slave (
        input  beginCount, pause, reloadMode, counterSeconds,
        output count, busy, done
    );
endinterface

// File: rtl/countdown_channel.sv
// One countdown channel: IDLE/RUN/PAUSED FSM, prescaler phase and count register.
module countdown_channel
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned TICKS_PER_UNIT = 50000000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             begin_count_i,
    input  logic             pause_i,
    input  logic             reload_mode_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             done_o
);
    localparam int unsigned PhaseWidth = prescaler_width(TICKS_PER_UNIT);
    localparam logic [PhaseWidth-1:0] PhaseLast = PhaseWidth'(TICKS_PER_UNIT - 1);

    timer_state_t          state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [WIDTH-1:0]      load_q, load_d;
    logic [PhaseWidth-1:0] phase_q, phase_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        load_d  = load_q;
        phase_d = phase_q;
        done_d  = 1'b0;

        if (begin_count_i) begin
            load_d  = load_value_i;
            count_d = load_value_i;
            phase_d = '0;
            if (load_value_i == '0) begin
                done_d  = 1'b1;
                state_d = StIdle;
            end else begin
                state_d = pause_i ? StPaused : StRun;
            end
        end else begin
            case (state_q)
                StRun, StPaused: begin
                    if (pause_i) begin
                        state_d = StPaused;
                    end else begin
                        // Leaving PAUSED advances on the same edge so no cycle is lost.
                        state_d = StRun;
                        if (phase_q == PhaseLast) begin
                            phase_d = '0;
                            if (count_q <= WIDTH'(1)) begin
                                done_d = 1'b1;
                                if (reload_mode_i) begin
                                    count_d = load_q;
                                end else begin
                                    count_d = '0;
                                    state_d = StIdle;
                                end
                            end else begin
                                count_d = count_q - 1'b1;
                            end
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StIdle;
            count_q <= '0;
            load_q  <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            load_q  <= load_d;
            phase_q <= phase_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign count_o = count_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule

// File: rtl/multi_countdown_timer.sv
// CHANNELS independent countdown timers with per-channel prescaler, pause,
// restart and optional auto-reload.
module multi_countdown_timer
    import timer_pkg::*;
#(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned CHANNELS       = 2,
    parameter int unsigned TICKS_PER_UNIT = 50000000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    multi_countdown_timer_if.slave  bus
);
    logic [CHANNELS*WIDTH-1:0] count_w;
    logic [CHANNELS-1:0]       busy_w;
    logic [CHANNELS-1:0]       done_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        countdown_channel #(
            .WIDTH          (WIDTH),
            .TICKS_PER_UNIT (TICKS_PER_UNIT)
        ) u_channel (
            .Clock         (Clock),
            .Reset         (Reset),
            .begin_count_i (bus.beginCount[i]),
            .pause_i       (bus.pause[i]),
            .reload_mode_i (bus.reloadMode[i]),
            .load_value_i  (bus.counterSeconds[i*WIDTH +: WIDTH]),
            .count_o       (count_w[i*WIDTH +: WIDTH]),
            .busy_o        (busy_w[i]),
            .done_o        (done_w[i])
        );
    end

    assign bus.count = count_w;
    assign bus.busy  = busy_w;
    assign bus.done  = done_w;

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Directed plus randomized bench for multi_countdown_timer against an
// elapsed-time reference model.
module tb_multi_countdown_timer;
    localparam int W = 10;
    localparam int C = 2;
    localparam int T = 3;

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    multi_countdown_timer_if #(.WIDTH(W), .CHANNELS(C)) ifc ();

    multi_countdown_timer #(
        .WIDTH          (W),
        .CHANNELS       (C),
        .TICKS_PER_UNIT (T)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (ifc)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: elapsed running cycles since load; count = load - elapsed / T.
    bit          m_active  [C];
    int unsigned m_load    [C];
    int unsigned m_elapsed [C];
    int unsigned m_count   [C];
    bit          m_done    [C];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_update();
        for (int c = 0; c < C; c++) begin
            if (Reset) begin
                m_active[c] = 0; m_load[c] = 0; m_elapsed[c] = 0;
                m_count[c] = 0; m_done[c] = 0;
            end else begin
                m_done[c] = 0;
                if (ifc.beginCount[c]) begin
                    m_load[c]    = ifc.counterSeconds[c*W +: W];
                    m_count[c]   = m_load[c];
                    m_elapsed[c] = 0;
                    m_active[c]  = (m_load[c] != 0);
                    m_done[c]    = (m_load[c] == 0);
                end else if (m_active[c] && !ifc.pause[c]) begin
                    m_elapsed[c]++;
                    if (m_elapsed[c] == m_load[c] * T) begin
                        m_done[c] = 1;
                        if (ifc.reloadMode[c]) begin
                            m_elapsed[c] = 0;
                            m_count[c]   = m_load[c];
                        end else begin
                            m_active[c] = 0;
                            m_count[c]  = 0;
                        end
                    end else begin
                        m_count[c] = m_load[c] - m_elapsed[c] / T;
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge Clock);
        model_update();
        cyc++;
        #1;
        for (int c = 0; c < C; c++) begin
            check($sformatf("count%0d", c), 32'(ifc.count[c*W +: W]), m_count[c]);
            check($sformatf("busy%0d", c), 32'(ifc.busy[c]), 32'(m_active[c]));
            check($sformatf("done%0d", c), 32'(ifc.done[c]), 32'(m_done[c]));
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input int c, input int unsigned v);
        ifc.counterSeconds[c*W +: W] = W'(v);
        ifc.beginCount[c] = 1'b1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    // Step until done[ch] is seen; an expired budget is a failed comparison.
    task automatic wait_done(input int ch, input int budget);
        bit hit;
        hit = 0;
        for (int n = 0; n < budget && !hit; n++) begin
            step();
            if (ifc.done[ch] === 1'b1) hit = 1;
        end
        if (!hit) check($sformatf("timeout_done%0d", ch), 0, 1);
    endtask

    int k;

    initial begin
        ifc.beginCount     = '0;
        ifc.pause          = '0;
        ifc.reloadMode     = '0;
        ifc.counterSeconds = '0;

        // Reset state
        Reset = 1'b1;
        steps(2);
        Reset = 1'b0;
        check("rst_count", 32'(ifc.count), 0);
        check("rst_busy", 32'(ifc.busy), 0);
        check("rst_done", 32'(ifc.done), 0);

        // 1. One-shot load 7
        do_reset();
        load(0, 7); step(); ifc.beginCount = '0; k = cyc;
        check("t1_load", 32'(ifc.count[W-1:0]), 7);
        steps(3);
        check("t1_first_dec", 32'(ifc.count[W-1:0]), 6);
        wait_done(0, 40);
        check("t1_done_at", cyc - k, 21);
        check("t1_busy_fall", 32'(ifc.busy[0]), 0);
        step();
        check("t1_done_1cyc", 32'(ifc.done[0]), 0);

        // 2. Pause for 6 cycles
        do_reset();
        load(0, 5); step(); ifc.beginCount = '0; k = cyc;
        steps(4);
        ifc.pause[0] = 1'b1;
        steps(6);
        check("t2_hold", 32'(ifc.count[W-1:0]), 4);
        ifc.pause[0] = 1'b0;
        wait_done(0, 40);
        check("t2_done_at", cyc - k, 21);

        // 3. Restart mid-count, then zero load
        do_reset();
        load(0, 7); step(); ifc.beginCount = '0; k = cyc;
        steps(9);
        load(0, 3); step(); ifc.beginCount = '0;
        check("t3_restart", 32'(ifc.count[W-1:0]), 3);
        wait_done(0, 40);
        check("t3_done_at", cyc - k, 19);
        load(0, 0); step(); ifc.beginCount = '0;
        check("t3_zero_done", 32'(ifc.done[0]), 1);
        check("t3_zero_busy", 32'(ifc.busy[0]), 0);
        step();
        check("t3_zero_busy2", 32'(ifc.busy[0]), 0);

        // 4. Auto-reload on channel 1
        do_reset();
        ifc.reloadMode[1] = 1'b1;
        load(1, 2); step(); ifc.beginCount = '0; k = cyc;
        for (int r = 1; r <= 3; r++) begin
            wait_done(1, 20);
            check("t4_done_at", cyc - k, 6 * r);
            check("t4_reload", 32'(ifc.count[2*W-1:W]), 2);
            check("t4_busy", 32'(ifc.busy[1]), 1);
        end
        ifc.reloadMode[1] = 1'b0;
        wait_done(1, 20);
        check("t4_oneshot_busy", 32'(ifc.busy[1]), 0);

        // 5. Independence, then reset mid-count
        do_reset();
        load(0, 7); load(1, 4); step(); ifc.beginCount = '0; k = cyc;
        wait_done(1, 40);
        check("t5_done1_at", cyc - k, 12);
        wait_done(0, 40);
        check("t5_done0_at", cyc - k, 21);
        load(0, 7); load(1, 4); step(); ifc.beginCount = '0;
        steps(4);
        Reset = 1'b1; step(); Reset = 1'b0;
        check("t5_rst_count", 32'(ifc.count), 0);
        check("t5_rst_busy", 32'(ifc.busy), 0);
        for (int i = 0; i < 30; i++) begin
            step();
            check("t5_no_done", 32'(ifc.done), 0);
        end

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < C; c++) begin
                ifc.beginCount[c] = ($urandom_range(0, 11) == 0);
                ifc.counterSeconds[c*W +: W] = W'($urandom_range(0, 9));
                if ($urandom_range(0, 5) == 0) ifc.pause[c] = ~ifc.pause[c];
                if ($urandom_range(0, 19) == 0) ifc.reloadMode[c] = ~ifc.reloadMode[c];
            end
            Reset = ($urandom_range(0, 199) == 0);
            step();
        end
        Reset = 1'b0;
        ifc.beginCount = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
